seg7_scan_monitor: RTL and testbench
====================================

SEG7_SCAN_MONITOR -- requirements
Module: seg7_scan_monitor

Interface
REQ-001 Parameter STABLE_CYC, default 4: number of consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 clk_i  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk_i.
REQ-004 A,B,C,D,E,F,G  input  1 each  observed segment lines, active-low (0 = lit).
REQ-005 An0,An1,An2,An3  input  1 each  observed digit-select anodes, active-low; An0 selects digit 0.
REQ-006 digit0_o,digit1_o,digit2_o,digit3_o  output  4 each  last decoded hex value per digit.
REQ-007 dig_valid_o  output  4  bit N high = digitN_o holds a successfully decoded value.
REQ-008 err_o  output  1  one-cycle pulse on capture of an undecodable segment pattern.
REQ-009 frame_o  output  1  one-cycle pulse when all four digits have been captured since the last frame, reset or error.

Function
REQ-010 The block SHALL register {An3..An0, A..G} in one input sample stage; all decisions SHALL use sampled values only.
REQ-011 Anode vector SHALL be valid only when exactly one anode bit is 0; any other vector (1111, 1100, 0000, ...) is idle.
REQ-012 A run counter SHALL be set to 1 when the sample differs from the previous sample, increment when it matches, and saturate at STABLE_CYC.
REQ-013 While the anode vector is idle, the run counter SHALL be held at 0 and no capture SHALL occur.
REQ-014 Capture SHALL occur exactly once per dwell, on the edge where the run counter reaches STABLE_CYC with a valid anode vector; no re-capture until the sample changes.
REQ-015 Latency: input stable from edge k SHALL produce updated outputs visible after edge k+STABLE_CYC+1.
REQ-016 Decode table, {A..G} active-low:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000
- C=0110001, d=1000010, E=0110000, F=0111000
REQ-017 On capture of a listed pattern: digitN_o <= value; dig_valid_o[N] <= 1; seen-mask bit N <= 1.
REQ-018 On capture of an unlisted pattern: err_o = 1 for one cycle; dig_valid_o[N] <= 0; digitN_o unchanged; seen-mask cleared to 0000.
REQ-019 When a capture makes the seen-mask 1111, frame_o SHALL pulse in the same cycle the new digit value appears and the mask SHALL clear to 0000.
REQ-020 Recapturing an already-seen digit SHALL update its value and SHALL NOT pulse frame_o.
REQ-021 err_o and frame_o SHALL never be high in the same cycle; each SHALL be high for at most one cycle per capture.
REQ-022 The block SHALL be purely observational: no outputs toward the display lines and no back-pressure.

Reset
REQ-023 While reset = 0 at a rising edge: digit0_o..digit3_o = 0, dig_valid_o = 0000, err_o = 0, frame_o = 0.
REQ-024 Reset SHALL also clear the run counter and seen-mask, and load the sample stage with all ones (idle, blank).
REQ-025 Reset asserted mid-dwell SHALL abort the pending capture; after release, a full STABLE_CYC dwell is needed before any capture.

Verification (STABLE_CYC = 4)
REQ-026 reset = 0 for 2 edges with arbitrary inputs -> all outputs 0, dig_valid_o = 0000.
REQ-027 An = 1110, seg = 0010010 held 6 cycles -> digit0_o = 2, dig_valid_o = 0001 after 5th edge; err_o and frame_o stay 0; no second update.
REQ-028 An = 1101, seg = 1001111 held 3 cycles, then changed -> no capture; digit1_o = 0; dig_valid_o unchanged.
REQ-029 Scan An0..An3 showing 1,2,3,4, each held 5 cycles -> digits = 1,2,3,4; dig_valid_o = 1111; exactly one frame_o pulse, coincident with digit3_o update.
REQ-030 An = 1011, seg = 1111110 held 5 cycles -> one err_o pulse; dig_valid_o[2] = 0; seen-mask cleared, so frame_o stays 0 on the next full scan of only 3 digits.
REQ-031 An = 1100 held 10 cycles -> no capture; reset = 0 at dwell cycle 3 of a valid digit -> no capture; outputs 0 per REQ-023.

Source files
------------

// File: rtl/seg7_scan_monitor_if.sv
// Observation bundle for the 7-segment scan monitor: sniffed display lines
// in, decoded digits and frame/error pulses out.
interface seg7_scan_monitor_if;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       E;
    logic       F;
    logic       G;
    logic       An0;
    logic       An1;
    logic       An2;
    logic       An3;
    logic [3:0] digit0_o;
    logic [3:0] digit1_o;
    logic [3:0] digit2_o;
    logic [3:0] digit3_o;
    logic [3:0] dig_valid_o;
    logic       err_o;
    logic       frame_o;

    modport master (
        output A, B, C, D, E, F, G,
        output An0, An1, An2, An3,
        input  digit0_o, digit1_o, digit2_o, digit3_o,
        input  dig_valid_o, err_o, frame_o
    );

    modport slave (
        input  A, B, C, D, E, F, G,
        input  An0, An1, An2, An3,
        output digit0_o, digit1_o, digit2_o, digit3_o,
        output dig_valid_o, err_o, frame_o
    );
endinterface

// File: rtl/seg7_scan_monitor.sv
// Passive monitor of a multiplexed 4-digit active-low 7-segment display:
// debounces each digit dwell and decodes the hex value shown on it.
module seg7_scan_monitor #(
    parameter int STABLE_CYC = 4
) (
    input  logic                 clk_i,
    input  logic                 reset,
    seg7_scan_monitor_if.slave   mon
);

    localparam logic [7:0] SAT    = 8'(STABLE_CYC);
    localparam logic [7:0] SAT_M1 = 8'(STABLE_CYC - 1);

    logic [10:0] r_smp;
    logic [10:0] r_prev;
    logic [7:0]  r_cnt;
    logic [3:0]  r_dig [4];
    logic [3:0]  r_vld;
    logic [3:0]  r_seen;
    logic        r_err;
    logic        r_frm;

    logic [3:0]  w_an;
    logic [6:0]  w_seg;
    logic        w_an_ok;
    logic        w_same;
    logic        w_cap;
    logic [7:0]  w_cnt_nxt;
    logic [1:0]  w_idx;
    logic [3:0]  w_bit;
    logic [3:0]  w_seen_nxt;
    logic [3:0]  w_hex;
    logic        w_hit;
    logic [10:0] w_raw;

    assign w_raw = {mon.An3, mon.An2, mon.An1, mon.An0,
                    mon.A, mon.B, mon.C, mon.D, mon.E, mon.F, mon.G};

    assign w_an    = ~r_smp[10:7];
    assign w_seg   = r_smp[6:0];
    assign w_an_ok = (w_an != 4'd0) && ((w_an & (w_an - 4'd1)) == 4'd0);
    assign w_same  = (r_smp == r_prev);

    // Idle anodes pin the run at 0 so a dwell always restarts from 1.
    always_comb begin
        w_cnt_nxt = 8'd0;
        if (!w_an_ok) begin
            w_cnt_nxt = 8'd0;
        end else if (!w_same) begin
            w_cnt_nxt = 8'd1;
        end else if (r_cnt == SAT) begin
            w_cnt_nxt = SAT;
        end else begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    assign w_cap = w_an_ok && w_same && (r_cnt == SAT_M1);

    always_comb begin
        w_idx = 2'd0;
        unique case (w_an)
            4'b0001: w_idx = 2'd0;
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    assign w_bit      = 4'd1 << w_idx;
    assign w_seen_nxt = r_seen | w_bit;

    always_comb begin
        w_hex = 4'h0;
        w_hit = 1'b1;
        unique case (w_seg)
            7'b0000001: w_hex = 4'h0;
            7'b1001111: w_hex = 4'h1;
            7'b0010010: w_hex = 4'h2;
            7'b0000110: w_hex = 4'h3;
            7'b1001100: w_hex = 4'h4;
            7'b0100100: w_hex = 4'h5;
            7'b0100000: w_hex = 4'h6;
            7'b0001111: w_hex = 4'h7;
            7'b0000000: w_hex = 4'h8;
            7'b0000100: w_hex = 4'h9;
            7'b0001000: w_hex = 4'hA;
            7'b1100000: w_hex = 4'hB;
            7'b0110001: w_hex = 4'hC;
            7'b1000010: w_hex = 4'hD;
            7'b0110000: w_hex = 4'hE;
            7'b0111000: w_hex = 4'hF;
            default:    w_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            r_smp  <= '1;
            r_prev <= '1;
            r_cnt  <= 8'd0;
            r_dig  <= '{default: 4'd0};
            r_vld  <= 4'd0;
            r_seen <= 4'd0;
            r_err  <= 1'b0;
            r_frm  <= 1'b0;
        end else begin
            r_prev <= r_smp;
            r_smp  <= w_raw;
            r_cnt  <= w_cnt_nxt;
            r_err  <= 1'b0;
            r_frm  <= 1'b0;
            if (w_cap) begin
                if (w_hit) begin
                    r_dig[w_idx] <= w_hex;
                    r_vld[w_idx] <= 1'b1;
                    if (w_seen_nxt == 4'hF) begin
                        r_frm  <= 1'b1;
                        r_seen <= 4'd0;
                    end else begin
                        r_seen <= w_seen_nxt;
                    end
                end else begin
                    r_err        <= 1'b1;
                    r_vld[w_idx] <= 1'b0;
                    r_seen       <= 4'd0;
                end
            end
        end
    end

    assign mon.digit0_o    = r_dig[0];
    assign mon.digit1_o    = r_dig[1];
    assign mon.digit2_o    = r_dig[2];
    assign mon.digit3_o    = r_dig[3];
    assign mon.dig_valid_o = r_vld;
    assign mon.err_o       = r_err;
    assign mon.frame_o     = r_frm;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Randomised bench for seg7_scan_monitor against a sliding-window model of
// the sampled display lines.
module tb_seg7_scan_monitor;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_monitor_if bus();

    seg7_scan_monitor #(.STABLE_CYC(S)) dut (
        .clk_i (clk),
        .reset (rst_n),
        .mon   (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_frm = 0;
    int n_err = 0;

    logic [6:0]  lut [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [10:0] hist [$];
    int          m_dig [4];
    logic [3:0]  m_val;
    logic [3:0]  m_seen;
    logic        m_err;
    logic        m_frm;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dec(input logic [6:0] s);
        int r;
        r = -1;
        for (int i = 0; i < 16; i++)
            if (lut[i] == s) r = i;
        return r;
    endfunction

    // Capture at this edge iff the last S samples are one valid vector and
    // the sample before them was different.
    task automatic model_edge(input logic [10:0] v, input logic rn);
        logic [10:0] cur;
        logic [3:0]  an;
        bit          cap;
        int          idx;
        int          hx;
        m_err = 1'b0;
        m_frm = 1'b0;
        if (!rn) begin
            m_dig  = '{default: 0};
            m_val  = 4'd0;
            m_seen = 4'd0;
            hist.push_back(11'h7FF);
        end else begin
            cur = hist[S];
            an  = ~cur[10:7];
            cap = ($countones(an) == 1) && (hist[0] != cur);
            for (int i = 1; i < S; i++)
                if (hist[i] != cur) cap = 0;
            if (cap) begin
                idx = 0;
                for (int i = 0; i < 4; i++)
                    if (an[i]) idx = i;
                hx = dec(cur[6:0]);
                if (hx >= 0) begin
                    m_dig[idx]  = hx;
                    m_val[idx]  = 1'b1;
                    m_seen[idx] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_frm  = 1'b1;
                        m_seen = 4'd0;
                    end
                end else begin
                    m_err      = 1'b1;
                    m_val[idx] = 1'b0;
                    m_seen     = 4'd0;
                end
            end
            hist.push_back(v);
        end
        void'(hist.pop_front());
    endtask

    task automatic cyc(input logic [3:0] an, input logic [6:0] seg,
                       input logic rn);
        {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = seg;
        {bus.An3, bus.An2, bus.An1, bus.An0} = an;
        rst_n = rn;
        @(posedge clk);
        model_edge({an, seg}, rn);
        #1;
        chk("digit0", bus.digit0_o, m_dig[0]);
        chk("digit1", bus.digit1_o, m_dig[1]);
        chk("digit2", bus.digit2_o, m_dig[2]);
        chk("digit3", bus.digit3_o, m_dig[3]);
        chk("valid", bus.dig_valid_o, m_val);
        chk("err", bus.err_o, m_err);
        chk("frame", bus.frame_o, m_frm);
        chk("err_frame_excl", bus.err_o & bus.frame_o, 0);
        if (bus.frame_o === 1'b1) n_frm++;
        if (bus.err_o === 1'b1) n_err++;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg,
                        input int n);
        for (int i = 0; i < n; i++) cyc(an, seg, 1'b1);
    endtask

    function automatic logic [3:0] sel(input int d);
        logic [3:0] a;
        a = 4'hF;
        a[d] = 1'b0;
        return a;
    endfunction

    initial begin
        int f0;
        int e0;
        int hl;
        int d;
        logic [3:0] an;
        logic [6:0] sg;
        for (int i = 0; i <= S; i++) hist.push_back(11'h7FF);
        m_dig  = '{default: 0};
        m_val  = 4'd0;
        m_seen = 4'd0;

        cyc(4'($urandom), 7'($urandom), 1'b0);
        cyc(4'($urandom), 7'($urandom), 1'b0);
        chk("rst_valid", bus.dig_valid_o, 4'd0);
        chk("rst_d0", bus.digit0_o, 4'd0);

        f0 = n_frm;
        e0 = n_err;
        hold(4'b1110, 7'b0010010, 6);
        chk("dwell_d0", bus.digit0_o, 4'd2);
        chk("dwell_valid", bus.dig_valid_o, 4'b0001);
        chk("dwell_quiet", (n_frm - f0) + (n_err - e0), 0);

        hold(4'b1101, 7'b1001111, 3);
        hold(4'b1111, 7'b1111111, 2);
        chk("short_d1", bus.digit1_o, 4'd0);
        chk("short_valid", bus.dig_valid_o, 4'b0001);

        f0 = n_frm;
        for (int i = 0; i < 4; i++) hold(sel(i), lut[i + 1], 5);
        chk("scan_d3", bus.digit3_o, 4'd4);
        chk("scan_valid", bus.dig_valid_o, 4'hF);
        chk("scan_frames", n_frm - f0, 1);

        f0 = n_frm;
        e0 = n_err;
        hold(sel(0), lut[5], 5);
        hold(sel(1), lut[6], 5);
        hold(4'b1011, 7'b1111110, 5);
        chk("bad_errs", n_err - e0, 1);
        chk("bad_valid2", bus.dig_valid_o[2], 1'b0);
        hold(sel(0), lut[7], 5);
        hold(sel(1), lut[8], 5);
        hold(sel(3), lut[9], 5);
        chk("bad_noframe", n_frm - f0, 0);

        hold(4'b1100, lut[3], 10);
        hold(sel(2), lut[12], 2);
        cyc(sel(2), lut[12], 1'b0);
        hold(sel(2), lut[12], 2);
        chk("midrst_valid", bus.dig_valid_o, 4'd0);
        chk("midrst_d2", bus.digit2_o, 4'd0);
        hold(sel(2), lut[12], 3);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int r = 0; r < int'($urandom_range(1, 2)); r++)
                    cyc(4'($urandom), 7'($urandom), 1'b0);
            end
            if ($urandom_range(0, 9) < 8) begin
                d  = int'($urandom_range(0, 3));
                an = sel(d);
            end else begin
                an = 4'($urandom);
            end
            if ($urandom_range(0, 9) < 8) sg = lut[$urandom_range(0, 15)];
            else sg = 7'($urandom);
            hl = int'($urandom_range(1, 7));
            hold(an, sg, hl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
